// File: rtl/alu_serial_seq_if.sv
// Request/response bundle for the bit-serial ALU sequencer.
// The master drives the operation request; the slave returns status and the result.
interface alu_serial_seq_if;
    logic        start;
    logic [2:0]  op;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        zf;
    logic        cf;
    logic        vf;
    logic        err;

    modport master (
        output start, op, opA, opB,
        input  busy, done, result, zf, cf, vf, err
    );

    modport slave (
        input  start, op, opA, opB,
        output busy, done, result, zf, cf, vf, err
    );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial 16-bit ALU sequencer: drives an external 1-bit ALU slice one bit per cycle,
// LSB first, and assembles the result and the zero/carry/overflow/error flags.
module alu_serial_seq (
    input  logic              clk,
    input  logic              reset,
    alu_serial_seq_if.slave   bus,
    output logic              slice_A,
    output logic              slice_B,
    output logic              slice_CIN,
    output logic              slice_Bnegate,
    output logic [2:0]        slice_operation,
    input  logic              slice_Result,
    input  logic              slice_cout
);
    localparam int unsigned W  = 16;
    localparam int unsigned IW = 4;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   acc;
    logic [IW-1:0]  idx;
    logic           carry;

    logic           op_valid_c;
    logic           arith_c;
    logic           last_c;
    logic [W-1:0]   res_final_c;

    // Operand bits come straight from the shift registers, which empty to zero by the end of RUN.
    assign slice_A   = a_sh[0];
    assign slice_B   = b_sh[0];
    assign slice_CIN = carry;

    always_comb begin
        op_valid_c = 1'b0;
        case (bus.op)
            OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB: op_valid_c = 1'b1;
            default:                               op_valid_c = 1'b0;
        endcase
        arith_c     = slice_operation[2];
        last_c      = (idx == IW'(W - 1));
        res_final_c = {slice_Result, acc[W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            a_sh            <= '0;
            b_sh            <= '0;
            acc             <= '0;
            idx             <= '0;
            carry           <= 1'b0;
            slice_operation <= 3'b000;
            slice_Bnegate   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.result      <= '0;
            bus.zf          <= 1'b0;
            bus.cf          <= 1'b0;
            bus.vf          <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy   <= 1'b1;
                        bus.result <= '0;
                        bus.zf     <= 1'b0;
                        bus.cf     <= 1'b0;
                        bus.vf     <= 1'b0;
                        if (op_valid_c) begin
                            state           <= RUN;
                            a_sh            <= bus.opA;
                            b_sh            <= bus.opB;
                            acc             <= '0;
                            idx             <= '0;
                            slice_operation <= bus.op;
                            slice_Bnegate   <= (bus.op == OP_SUB);
                            carry           <= (bus.op == OP_SUB);
                            bus.err         <= 1'b0;
                        end else begin
                            state    <= DONE;
                            bus.err  <= 1'b1;
                            bus.done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    acc   <= res_final_c;
                    idx   <= idx + IW'(1);
                    carry <= arith_c & slice_cout;
                    if (last_c) begin
                        // Bit 15: carry register still holds its carry-in, so overflow is cin ^ cout.
                        state           <= DONE;
                        bus.done        <= 1'b1;
                        bus.result      <= res_final_c;
                        bus.zf          <= (res_final_c == '0);
                        bus.cf          <= arith_c & slice_cout;
                        bus.vf          <= arith_c & (carry ^ slice_cout);
                        carry           <= 1'b0;
                        idx             <= '0;
                        slice_operation <= 3'b000;
                        slice_Bnegate   <= 1'b0;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
